// File: rtl/acoustics_pkg.sv
// Shared definitions for the acoustics capture path: capture FSM encoding and
// default SRAM geometry.
package acoustics_pkg;

   localparam int SRAM_ADDR_W = 16;
   localparam int SRAM_DATA_W = 16;
   localparam int CAP_DROP_W  = 16;

   typedef enum logic [1:0] {
      CAP_IDLE  = 2'd0,
      CAP_FILL  = 2'd1,
      CAP_STALL = 2'd2
   } cap_state_e;

endpackage

// File: rtl/capture_pingpong_ctrl_if.sv
// Signal bundle between the ADC/DSP side and the ping-pong capture controller,
// including the SRAM port A write bus.
interface capture_pingpong_ctrl_if #(
   parameter int ADDR_W = acoustics_pkg::SRAM_ADDR_W,
   parameter int DATA_W = acoustics_pkg::SRAM_DATA_W,
   parameter int DROP_W = acoustics_pkg::CAP_DROP_W
);

   logic              enable;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              dsp_ack;
   logic              clear_ovr;

   logic              ram_ena;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina;

   logic              buf_ready;
   logic              ready_bank;
   logic              overrun;
   logic [DROP_W-1:0] drop_count;

   modport master (
      output enable, sample_valid, sample_data, dsp_ack, clear_ovr,
      input  ram_ena, ram_wea, ram_addra, ram_dina,
      input  buf_ready, ready_bank, overrun, drop_count
   );

   modport slave (
      input  enable, sample_valid, sample_data, dsp_ack, clear_ovr,
      output ram_ena, ram_wea, ram_addra, ram_dina,
      output buf_ready, ready_bank, overrun, drop_count
   );

endinterface

// File: rtl/capture_pingpong_ctrl_pulse_sync.sv
// Two-flop synchronizer plus rising-edge detect for asynchronous DSP strobes.
// The strobe must stay high for at least two clk periods to be seen.
module pulse_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse_out
);

   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   // sync_q[2] is only the edge-detect history, not a third sync stage
   assign pulse_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/capture_pingpong_ctrl.sv
// Port A sequencer for the acoustics sample SRAM: fills the two halves alternately,
// hands each full half to the DSP and drops samples while both halves are held.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   CAP_IDLE  | capture stopped; wptr and ownership cleared
//   CAP_FILL  | writing samples into the half selected by wptr
//   CAP_STALL | the half wptr points into is still DSP-owned; samples dropped
module capture_pingpong_ctrl
   import acoustics_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W,
   parameter int DROP_W = CAP_DROP_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   capture_pingpong_ctrl_if.slave cap
);

   cap_state_e        state;
   logic [ADDR_W-1:0] wptr;
   logic [1:0]        own;
   logic              ready_bank;
   logic              buf_ready;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina;
   logic              overrun;
   logic [DROP_W-1:0] drop_count;

   logic       ack_p;
   logic [1:0] own_ack;
   logic       rb_ack;
   logic [1:0] own_nxt;
   logic       rb_nxt;
   logic       wr_half;
   logic       half_last;
   logic       do_write;
   logic       do_drop;
   logic       go_stall;

   pulse_sync u_ack_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (cap.dsp_ack),
      .pulse_out(ack_p)
   );

   assign wr_half   = wptr[ADDR_W-1];
   assign half_last = &wptr[ADDR_W-2:0];

   // The ack is folded in before the half-completion so a release in the same
   // cycle as the last write of a half can prevent the stall.
   always_comb begin
      own_ack = own;
      rb_ack  = ready_bank;
      if (ack_p && (own != 2'b00)) begin
         own_ack[ready_bank] = 1'b0;
         if (own[~ready_bank]) begin
            rb_ack = ~ready_bank;
         end
      end
   end

   always_comb begin
      do_write = cap.enable && cap.sample_valid &&
                 ((state == CAP_FILL) || ((state == CAP_STALL) && !own_ack[wr_half]));
      do_drop  = cap.enable && cap.sample_valid &&
                 (state == CAP_STALL) && own_ack[wr_half];
   end

   always_comb begin
      own_nxt  = own_ack;
      rb_nxt   = rb_ack;
      go_stall = 1'b0;
      if (do_write && half_last) begin
         own_nxt[wr_half] = 1'b1;
         if (own_ack == 2'b00) begin
            rb_nxt = wr_half;
         end
         go_stall = own_ack[~wr_half];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= CAP_IDLE;
         wptr       <= '0;
         own        <= 2'b00;
         ready_bank <= 1'b0;
         buf_ready  <= 1'b0;
         ram_wea    <= 1'b0;
         ram_addra  <= '0;
         ram_dina   <= '0;
         overrun    <= 1'b0;
         drop_count <= '0;
      end else begin
         ram_wea <= 1'b0;

         if (cap.clear_ovr) begin
            overrun    <= 1'b0;
            drop_count <= '0;
         end else if (do_drop) begin
            overrun <= 1'b1;
            if (drop_count != {DROP_W{1'b1}}) begin
               drop_count <= drop_count + DROP_W'(1);
            end
         end

         if (!cap.enable) begin
            state      <= CAP_IDLE;
            wptr       <= '0;
            own        <= 2'b00;
            ready_bank <= 1'b0;
            buf_ready  <= 1'b0;
         end else begin
            own        <= own_nxt;
            ready_bank <= rb_nxt;
            buf_ready  <= |own;
            case (state)
               CAP_IDLE: begin
                  state <= CAP_FILL;
               end
               CAP_FILL, CAP_STALL: begin
                  if (do_write) begin
                     ram_wea   <= 1'b1;
                     ram_addra <= wptr;
                     ram_dina  <= cap.sample_data;
                     wptr      <= wptr + ADDR_W'(1);
                     state     <= go_stall ? CAP_STALL : CAP_FILL;
                  end else if ((state == CAP_STALL) && !own_ack[wr_half]) begin
                     state <= CAP_FILL;
                  end
               end
               default: begin
                  state <= CAP_IDLE;
               end
            endcase
         end
      end
   end

   assign cap.ram_ena    = ram_wea;
   assign cap.ram_wea    = ram_wea;
   assign cap.ram_addra  = ram_addra;
   assign cap.ram_dina   = ram_dina;
   assign cap.buf_ready  = buf_ready;
   assign cap.ready_bank = ready_bank;
   assign cap.overrun    = overrun;
   assign cap.drop_count = drop_count;

endmodule
